vldst_seq: RTL and testbench

VLDST_SEQ -- requirements
Module: vldst_seq

---
 rtl/vldst_seq_pkg.sv | 20 ++
 rtl/vldst_addrgen.sv | 54 +++++
 rtl/vldst_seq.sv | 147 ++++++++++++++
 tb/tb_vldst_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/vldst_seq_pkg.sv
// Shared definitions for the vector load/store sequencer: FSM state encoding,
// op encodings and default geometry.
package vldst_seq_pkg;

    localparam int unsigned ELEMS_DEF = 16;   // elements per vector
    localparam int unsigned EW_DEF    = 16;   // element / memory word width
    localparam int unsigned AW        = 16;   // memory word address width

    localparam logic VLD_OP = 1'b0;
    localparam logic VST_OP = 1'b1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        LCAP  = 3'd2,
        STORE = 3'd3,
        DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/vldst_addrgen.sv
// Address generator: base register plus element counter, registered address.
// Optional overflow compare on the incoming base when VLDST_OVF_EN is defined;
// otherwise addresses wrap modulo 2^16.
// Ports: Clk1, Reset (sync, active-high); load latches baseIn and clears the
// counter; advance steps to the next element; addr = base + idx (registered);
// idx = element counter; last_c = counter at final element; ovf_c = baseIn
// range would run past 16'hFFFF.
module vldst_addrgen
    import vldst_seq_pkg::*;
#(
    parameter int unsigned ELEMS = ELEMS_DEF,
    parameter int unsigned CW    = (ELEMS > 1) ? $clog2(ELEMS) : 1
)(
    input  logic          Clk1,
    input  logic          Reset,
    input  logic          load,
    input  logic          advance,
    input  logic [AW-1:0] baseIn,
    output logic [AW-1:0] addr,
    output logic [CW-1:0] idx,
    output logic          last_c,
    output logic          ovf_c
);

    localparam int unsigned OW = AW + 1;

    logic [AW-1:0] baseReg;

    // Base/counter/address registers; the 16-bit sum wraps naturally.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            baseReg <= '0;
            idx     <= '0;
            addr    <= '0;
        end else if (load) begin
            baseReg <= baseIn;
            idx     <= '0;
            addr    <= baseIn;
        end else if (advance) begin
            idx     <= idx + CW'(1);
            addr    <= baseReg + AW'(idx) + AW'(1);
        end
    end

    assign last_c = (idx == CW'(ELEMS - 1));

`ifdef VLDST_OVF_EN
    // Widened compare so base+ELEMS-1 past 16'hFFFF is visible.
    assign ovf_c = (OW'(baseIn) + OW'(ELEMS - 1)) > OW'({AW{1'b1}});
`else
    assign ovf_c = 1'b0;
`endif

endmodule

// File: rtl/vldst_seq.sv
// Vector load/store sequencer: moves ELEMS words between memory and a vector
// register, one word per cycle, with one-cycle memory read latency.
// Optional feature macro: VLDST_OVF_EN (address-overflow error instead of wrap).
// Ports: Clk1, Reset (sync, active-high); start/op/baseAddr/vecIn request;
// DataIn memory read data; busy/done/err status; vecOut + vecWR load result;
// Addr/RD/WR/DataOut memory interface. All outputs registered.
module vldst_seq
    import vldst_seq_pkg::*;
#(
    parameter int unsigned ELEMS = ELEMS_DEF,
    parameter int unsigned EW    = EW_DEF
)(
    input  logic                Clk1,
    input  logic                Reset,
    input  logic                start,
    input  logic                op,
    input  logic [AW-1:0]       baseAddr,
    input  logic [ELEMS*EW-1:0] vecIn,
    input  logic [EW-1:0]       DataIn,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [ELEMS*EW-1:0] vecOut,
    output logic                vecWR,
    output logic [AW-1:0]       Addr,
    output logic                RD,
    output logic                WR,
    output logic [EW-1:0]       DataOut
);

    localparam int unsigned CW = (ELEMS > 1) ? $clog2(ELEMS) : 1;
    localparam int unsigned VW = ELEMS * EW;

    state_t        state;
    logic [VW-1:0] srcVec;
    logic [CW-1:0] idx;
    logic          lastIdx_c;
    logic          ovf_c;
    logic          accept_c;
    logic          advance_c;

    assign accept_c  = (state == IDLE) && start;
    assign advance_c = ((state == LOAD) || (state == STORE)) && !lastIdx_c;

    vldst_addrgen #(
        .ELEMS (ELEMS),
        .CW    (CW)
    ) u_addrgen (
        .Clk1    (Clk1),
        .Reset   (Reset),
        .load    (accept_c),
        .advance (advance_c),
        .baseIn  (baseAddr),
        .addr    (Addr),
        .idx     (idx),
        .last_c  (lastIdx_c),
        .ovf_c   (ovf_c)
    );

    // Sequencer FSM with registered strobes and status.
    always_ff @(posedge Clk1) begin
        if (Reset) begin
            state   <= IDLE;
            busy    <= 1'b0;
            done    <= 1'b0;
            vecWR   <= 1'b0;
            RD      <= 1'b0;
            WR      <= 1'b0;
            DataOut <= '0;
            vecOut  <= '0;
            srcVec  <= '0;
`ifdef VLDST_OVF_EN
            err     <= 1'b0;
`endif
        end else begin
            done  <= 1'b0;
            vecWR <= 1'b0;
`ifdef VLDST_OVF_EN
            err   <= 1'b0;
`endif
            unique case (state)
                IDLE: begin
                    if (start) begin
                        if (op == VST_OP) begin
                            srcVec <= vecIn;
                        end
                        if (ovf_c) begin
                            // Out-of-range request: no memory traffic at all.
                            state <= DONE;
                            done  <= 1'b1;
`ifdef VLDST_OVF_EN
                            err   <= 1'b1;
`endif
                        end else if (op == VLD_OP) begin
                            state <= LOAD;
                            busy  <= 1'b1;
                            RD    <= 1'b1;
                        end else begin
                            state   <= STORE;
                            busy    <= 1'b1;
                            WR      <= 1'b1;
                            DataOut <= vecIn[EW-1:0];
                        end
                    end
                end
                LOAD: begin
                    // DataIn now carries the word addressed one cycle earlier.
                    if (idx != '0) begin
                        vecOut[EW*int'(idx - CW'(1)) +: EW] <= DataIn;
                    end
                    if (lastIdx_c) begin
                        RD    <= 1'b0;
                        state <= LCAP;
                    end
                end
                LCAP: begin
                    vecOut[VW-1 -: EW] <= DataIn;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    vecWR <= 1'b1;
                    state <= DONE;
                end
                STORE: begin
                    if (lastIdx_c) begin
                        WR    <= 1'b0;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        DataOut <= srcVec[EW*(int'(idx) + 1) +: EW];
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifndef VLDST_OVF_EN
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vldst_seq.sv
// Self-checking bench for vldst_seq: directed table rows, randomized rows
// checked against a memory-array reference model, plus busy/reset sequences.
module tb_vldst_seq;

    localparam int ELEMS = 16;
    localparam int EW    = 16;
    localparam int VW    = ELEMS * EW;

`ifdef VLDST_OVF_EN
    localparam int   WRAP_LD_LAT = 1;
    localparam int   WRAP_ST_LAT = 1;
    localparam logic WRAP_ERR    = 1'b1;
`else
    localparam int   WRAP_LD_LAT = ELEMS + 2;
    localparam int   WRAP_ST_LAT = ELEMS + 1;
    localparam logic WRAP_ERR    = 1'b0;
`endif

    logic          Clk1 = 1'b0;
    logic          Reset = 1'b1;
    logic          start = 1'b0;
    logic          op = 1'b0;
    logic [15:0]   baseAddr = '0;
    logic [VW-1:0] vecIn = '0;
    logic [EW-1:0] DataIn = '0;
    logic          busy, done, err, vecWR, RD, WR;
    logic [VW-1:0] vecOut;
    logic [15:0]   Addr;
    logic [EW-1:0] DataOut;

    vldst_seq #(.ELEMS(ELEMS), .EW(EW)) dut (
        .Clk1(Clk1), .Reset(Reset), .start(start), .op(op), .baseAddr(baseAddr),
        .vecIn(vecIn), .DataIn(DataIn), .busy(busy), .done(done), .err(err),
        .vecOut(vecOut), .vecWR(vecWR), .Addr(Addr), .RD(RD), .WR(WR),
        .DataOut(DataOut)
    );

    always #5 Clk1 = ~Clk1;

    int cyc = 0;
    always @(posedge Clk1) cyc <= cyc + 1;

    // Memory with one-cycle read latency.
    logic [15:0] mem [0:65535];
    always @(posedge Clk1) begin
        if (RD) DataIn <= mem[Addr];
        if (WR) mem[Addr] <= DataOut;
    end

    // Observation log, sampled mid-cycle.
    logic [15:0]   rdQ[$];
    logic [15:0]   wrAQ[$];
    logic [15:0]   wrDQ[$];
    int            firstStrobe, doneCycle, doneCnt, busyCnt, vecWRcnt, bothHigh;
    logic          errAtDone;
    logic [VW-1:0] vecOutAtDone;

    always @(negedge Clk1) begin
        if (RD) begin rdQ.push_back(Addr); if (firstStrobe < 0) firstStrobe = cyc; end
        if (WR) begin
            wrAQ.push_back(Addr); wrDQ.push_back(DataOut);
            if (firstStrobe < 0) firstStrobe = cyc;
        end
        if (RD && WR) bothHigh++;
        if (busy) busyCnt++;
        if (vecWR) vecWRcnt++;
        if (done) begin
            doneCnt++;
            if (doneCycle < 0) begin doneCycle = cyc; errAtDone = err; vecOutAtDone = vecOut; end
        end
    end

    int nVec = 0;
    int nMis = 0;
    logic [VW-1:0] modelVec = '0;

    task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
        nVec++;
        if (act !== exp) begin
            nMis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: overflow rule and latency from the request alone.
    function automatic void modelLat(input logic o, input logic [15:0] b,
                                     output int lat, output logic e);
        logic ovf;
`ifdef VLDST_OVF_EN
        ovf = (32'(b) + 32'(ELEMS - 1)) > 32'hFFFF;
`else
        ovf = 1'b0;
`endif
        e   = ovf;
        lat = ovf ? 1 : (o ? ELEMS + 1 : ELEMS + 2);
    endfunction

    task automatic clearLog();
        rdQ.delete(); wrAQ.delete(); wrDQ.delete();
        firstStrobe = -1; doneCycle = -1; doneCnt = 0; busyCnt = 0;
        vecWRcnt = 0; bothHigh = 0;
    endtask

    task automatic runTxn(input logic o, input logic [15:0] b, input logic [VW-1:0] v,
                          input logic midStart, input int expLat, input logic expErr);
        logic [VW-1:0] expV;
        int sc, bad, n;
        expV = modelVec;
        if (o == 1'b0 && !expErr)
            for (int k = 0; k < ELEMS; k++) expV[k*EW +: EW] = mem[16'(b + 16'(k))];
        n = expErr ? 0 : ELEMS;
        clearLog();
        @(negedge Clk1);
        start = 1'b1; op = o; baseAddr = b; vecIn = v; sc = cyc;
        @(negedge Clk1);
        // Scramble request inputs to prove they were latched.
        start = 1'b0; op = ~o; baseAddr = ~b; vecIn = ~v;
        for (int i = 0; i < 64 && doneCycle < 0; i++) begin
            @(negedge Clk1); #1;
            start = (midStart && cyc == sc + 5);
        end
        start = 1'b0;
        if (doneCycle < 0) begin
            chk("done_timeout", VW'(0), VW'(1));
            return;
        end
        chk("latency", VW'(doneCycle - sc), VW'(expLat));
        chk("err", VW'(errAtDone), VW'(expErr));
        chk("vecWR_count", VW'(vecWRcnt), VW'((o == 1'b0) && !expErr));
        chk("busy_cycles", VW'(busyCnt), VW'(expLat - 1));
        chk("rd_wr_overlap", VW'(bothHigh), VW'(0));
        chk("rd_count", VW'(rdQ.size()), VW'(o ? 0 : n));
        chk("wr_count", VW'(wrAQ.size()), VW'(o ? n : 0));
        bad = 0;
        if (o == 1'b0) begin
            for (int k = 0; k < rdQ.size() && k < ELEMS; k++)
                if (rdQ[k] !== 16'(b + 16'(k))) bad++;
        end else begin
            for (int k = 0; k < wrAQ.size() && k < ELEMS; k++)
                if (wrAQ[k] !== 16'(b + 16'(k)) || wrDQ[k] !== v[k*EW +: EW]) bad++;
        end
        chk("addr_data_seq", VW'(bad), VW'(0));
        if (!expErr) chk("first_strobe_delay", VW'(firstStrobe - sc), VW'(1));
        chk("vecOut", vecOutAtDone, expV);
        modelVec = expV;
    endtask

    typedef struct {
        logic          op;
        logic [15:0]   base;
        logic [VW-1:0] vin;
        logic          midStart;
        int            expLat;
        logic          expErr;
    } vec_t;

    vec_t tbl[$];

    initial begin
        logic [VW-1:0] vA, vr;
        int lat, sc;
        logic e, o;
        logic [15:0] b;

        for (int i = 0; i < 65536; i++) mem[i] = 16'($urandom);
        for (int k = 0; k < ELEMS; k++) mem[16'h0040 + k] = 16'h1000 + 16'(k);
        for (int k = 0; k < ELEMS; k++) vA[k*EW +: EW] = 16'hA000 + 16'(k);
        for (int w = 0; w < VW / 32; w++) vr[w*32 +: 32] = $urandom;

        tbl.push_back('{1'b0, 16'h0040, '0, 1'b0, ELEMS + 2, 1'b0});
        tbl.push_back('{1'b1, 16'h0100, vA, 1'b0, ELEMS + 1, 1'b0});
        tbl.push_back('{1'b0, 16'hFFF8, '0, 1'b0, WRAP_LD_LAT, WRAP_ERR});
        tbl.push_back('{1'b1, 16'hFFFC, vr, 1'b0, WRAP_ST_LAT, WRAP_ERR});
        tbl.push_back('{1'b0, 16'hFFF0, '0, 1'b0, ELEMS + 2, 1'b0});
        tbl.push_back('{1'b0, 16'h1234, '0, 1'b1, ELEMS + 2, 1'b0});
        tbl.push_back('{1'b1, 16'h0000, ~vA, 1'b0, ELEMS + 1, 1'b0});
        tbl.push_back('{1'b0, 16'h0100, '0, 1'b0, ELEMS + 2, 1'b0});
        for (int r = 0; r < 16; r++) begin
            o = 1'($urandom);
            b = ($urandom_range(0, 3) == 0) ? 16'hFFF0 + 16'($urandom_range(0, 15)) : 16'($urandom);
            for (int w = 0; w < VW / 32; w++) vr[w*32 +: 32] = $urandom;
            modelLat(o, b, lat, e);
            tbl.push_back('{o, b, vr, 1'($urandom_range(0, 1)), lat, e});
        end

        // Reset state.
        repeat (3) @(negedge Clk1);
        chk("rst_busy", VW'(busy), VW'(0));
        chk("rst_done", VW'(done), VW'(0));
        chk("rst_err", VW'(err), VW'(0));
        chk("rst_strobes", VW'({vecWR, RD, WR}), VW'(0));
        chk("rst_addr", VW'(Addr), VW'(0));
        chk("rst_dataout", VW'(DataOut), VW'(0));
        chk("rst_vecOut", vecOut, '0);
        Reset = 1'b0;
        @(negedge Clk1);

        // Table rows, each starting in the cycle right after the previous done.
        foreach (tbl[i])
            runTxn(tbl[i].op, tbl[i].base, tbl[i].vin, tbl[i].midStart,
                   tbl[i].expLat, tbl[i].expErr);

        // Make vecOut non-zero before the reset abort.
        runTxn(1'b0, 16'h0040, '0, 1'b0, ELEMS + 2, 1'b0);

        // Reset in the middle of a store, at element 5.
        clearLog();
        @(negedge Clk1);
        start = 1'b1; op = 1'b1; baseAddr = 16'h0200; vecIn = vA; sc = cyc;
        @(negedge Clk1);
        start = 1'b0;
        for (int i = 0; i < 20 && cyc < sc + 6; i++) @(negedge Clk1);
        #1;
        chk("pre_reset_wr", VW'(WR), VW'(1));
        chk("pre_reset_addr", VW'(Addr), VW'(16'h0205));
        Reset = 1'b1;
        @(negedge Clk1); #1;
        chk("abort_wr", VW'(WR), VW'(0));
        chk("abort_busy", VW'(busy), VW'(0));
        chk("abort_vecOut", vecOut, '0);
        chk("abort_addr", VW'(Addr), VW'(0));
        Reset = 1'b0;
        repeat (25) @(negedge Clk1);
        chk("abort_no_done", VW'(doneCnt), VW'(0));
        chk("abort_no_vecWR", VW'(vecWRcnt), VW'(0));
        modelVec = '0;

        // Recovery after the abort.
        runTxn(1'b0, 16'h0200, '0, 1'b0, ELEMS + 2, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
        $finish;
    end

endmodule
